data_synchronizer: RTL and testbench

Multi-flop bus synchronizer that moves a multi-bit data word from an asynchronous source domain into the destination clock domain. Only the single-bit `asynchronous_data_valid` qualifier passes through a flop chain. Its synchronized rising edge becomes a one-cycle enable pulse. That pulse captures the quasi-static `asynchronous_data` bus and asserts `synchronous_data_valid` for exactly one destination cycle. It sits at the destination side of any clock-domain crossing where the source holds data stable while valid is high.

---
 rtl/data_synchronizer.sv | 51 +++++
 tb/tb_data_synchronizer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/data_synchronizer.sv
// Destination-side bus synchronizer: only the valid qualifier crosses through a flop chain,
// and its synchronized rising edge loads the quasi-static data bus for one valid cycle.
module data_synchronizer #(
  parameter int STAGE_COUNT = 2,
  parameter int BUS_WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 asynchronous_data_valid,
  input  logic [BUS_WIDTH-1:0] asynchronous_data,
  output logic                 Q_pulse_generator,
  output logic [BUS_WIDTH-1:0] synchronous_data,
  output logic                 synchronous_data_valid
);

  logic [STAGE_COUNT-1:0] sync_q, sync_d;
  logic                   pulse_q, pulse_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   sync_valid;
  logic                   enable_pulse;

  always_comb begin
    sync_d       = {sync_q[STAGE_COUNT-2:0], asynchronous_data_valid};
    sync_valid   = sync_q[STAGE_COUNT-1];
    // Rising-edge detect only: a falling synchronized valid never produces a pulse.
    enable_pulse = sync_valid & ~pulse_q;
    pulse_d      = sync_valid;
    data_d       = enable_pulse ? asynchronous_data : data_q;
    valid_d      = enable_pulse;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      pulse_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign Q_pulse_generator      = pulse_q;
  assign synchronous_data       = data_q;
  assign synchronous_data_valid = valid_q;

endmodule

// File: tb/tb_data_synchronizer.sv
// Randomized scoreboard bench for data_synchronizer: stimulus queues expected words with
// their due cycle, an independent monitor pops and compares on every valid pulse.
module tb_data_synchronizer;
  localparam int SC = 2;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          av;
  logic [BW-1:0] ad;
  logic          q_pg;
  logic [BW-1:0] sdata;
  logic          svalid;

  data_synchronizer #(.STAGE_COUNT(SC), .BUS_WIDTH(BW)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .asynchronous_data_valid(av),
    .asynchronous_data      (ad),
    .Q_pulse_generator      (q_pg),
    .synchronous_data       (sdata),
    .synchronous_data_valid (svalid)
  );

  always #6 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [BW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  // Monitor: every pulse must match the oldest expectation, arrive on its due cycle, last one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1) begin
      if (sb.size() > 0 && cyc > sb[0].due && !svalid) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_pulse: no pulse by cycle %0d, required word %h due at cycle %0d", cyc, e.data, e.due);
      end
      if (svalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: pulse at cycle %0d with data %h, required no pulse", cyc, sdata);
        end else begin
          e = sb.pop_front();
          if (sdata !== e.data || cyc != e.due) begin
            errors++;
            $display("FAIL pulse_data: got data %h at cycle %0d, required %h at cycle %0d", sdata, cyc, e.data, e.due);
          end
        end
        checks++;
        if (prev_valid) begin
          errors++;
          $display("FAIL pulse_width: valid high on consecutive cycles at %0d, required single cycle", cyc);
        end
      end
      prev_valid = svalid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"},  sdata, '0);
    check({tag, "_valid"}, BW'(svalid), '0);
    check({tag, "_qpg"},   BW'(q_pg), '0);
  endtask

  task automatic raise(input logic [BW-1:0] w);
    @(negedge clk);
    ad = w;
    av = 1'b1;
    sb.push_back('{data: w, due: cyc + 1 + SC});
    $display("raise word %h at cycle %0d", w, cyc);
  endtask

  task automatic send(input logic [BW-1:0] w, input int hold);
    raise(w);
    repeat (hold) @(negedge clk);
    av = 1'b0;
    repeat (SC + 4) @(negedge clk);
  endtask

  initial begin
    int c0, d0;
    reset = 1'b0;
    av    = 1'b0;
    ad    = '0;
    #1 check_zero("reset");
    #11;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check_zero("idle");

    // Basic crossing
    send(4'b1010, 1);
    check("basic_data", sdata, 4'b1010);

    // Exhaustive sweep with random hold lengths
    for (int i = 0; i < 16; i++) begin
      send(BW'(i), int'($urandom_range(1, 4)));
      check("sweep_data", sdata, BW'(i));
    end

    // Held valid: one pulse, Q_pulse_generator high from pulse until drop + SC
    raise(4'hC);
    c0 = cyc;
    d0 = c0 + 20;
    for (int k = 0; k < 20 + SC + 4; k++) begin
      @(negedge clk);
      if (cyc == d0) av = 1'b0;
      check("held_qpg", BW'(q_pg), BW'((cyc >= c0 + 1 + SC && cyc <= d0 + SC) ? 1 : 0));
    end
    check("held_data", sdata, 4'hC);

    // Hold behaviour: data changes with valid low must not propagate
    send(4'h5, 2);
    ad = 4'hA;
    repeat (10) @(negedge clk);
    check("hold_data", sdata, 4'h5);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      send(BW'($urandom), int'($urandom_range(1, 6)));
    end

    // Reset mid-crossing, released with valid still high
    raise(4'h7);
    @(negedge clk);
    #2 reset = 1'b0;
    sb.delete();
    #1 check_zero("midreset");
    repeat (2) @(negedge clk);
    check_zero("midreset_hold");
    reset = 1'b1;
    sb.push_back('{data: 4'h7, due: cyc + 1 + SC});
    repeat (SC + 3) @(negedge clk);
    check("release_data", sdata, 4'h7);
    av = 1'b0;
    repeat (SC + 4) @(negedge clk);

    // Drain: every expected word must have been seen
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected words pending, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
